spi_prog_timer: RTL

- EEPROM program sequencer directly downstream of the SPI CS/valid-detect front-end.
- Consumes the write-busy flag that the SPI front-end sets on CS rising when a program is enabled.
- Runs the high-voltage pump / erase / write / discharge timing on the system clock.
- On completion, returns the active-low clear (spi_wbusy_rst_n) that resets that busy flag, closing the loop.

---
 rtl/spi_prog_timer.sv | 129 ++++++++++++
 1 files changed

// File: rtl/spi_prog_timer.sv
// spi_prog_timer: EEPROM pump/erase/write/discharge sequencer that clears the SPI write-busy flag when done.
module spi_prog_timer #(
    parameter int CNT_W   = 16,
    parameter int T_PUMP  = 200,
    parameter int T_ERASE = 2000,
    parameter int T_WRITE = 2000,
    parameter int T_DISCH = 100,
    parameter int CLR_W   = 2
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       spi_ee_wbusy,
    input  logic [1:0] prog_mode,
    input  logic       lvd_n,
    output logic       hv_pump_en,
    output logic       ee_erase,
    output logic       ee_write,
    output logic       hv_disch,
    output logic       spi_wbusy_rst_n,
    output logic       prog_busy,
    output logic       prog_done,
    output logic       prog_err
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] PUMP  = 3'd1;
    localparam logic [2:0] ERASE = 3'd2;
    localparam logic [2:0] WRITE = 3'd3;
    localparam logic [2:0] DISCH = 3'd4;
    localparam logic [2:0] CLEAR = 3'd5;
    localparam int CLR_B = $clog2(CLR_W + 4);
    localparam logic [CNT_W-1:0] LD_PUMP  = CNT_W'(T_PUMP - 1);
    localparam logic [CNT_W-1:0] LD_ERASE = CNT_W'(T_ERASE - 1);
    localparam logic [CNT_W-1:0] LD_WRITE = CNT_W'(T_WRITE - 1);
    localparam logic [CNT_W-1:0] LD_DISCH = CNT_W'(T_DISCH - 1);
    localparam logic [CLR_B-1:0] CLR_LAST = CLR_B'(CLR_W - 1);
    localparam logic [CLR_B-1:0] CLR_LOW  = CLR_B'(CLR_W);
    localparam logic [CLR_B-1:0] CLR_TOP  = CLR_B'(CLR_W + 3);

    logic [1:0]       sync;
    logic             wbusy_s;
    logic [2:0]       state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [CLR_B-1:0] clr, clr_nx;
    logic [1:0]       mode, mode_nx;
    logic             err_nx, hv, abort, cnt_z, skip_erase, skip_write;

    assign wbusy_s    = sync[1];
    assign hv         = state == PUMP || state == ERASE || state == WRITE;
    assign abort      = hv && !lvd_n;
    assign cnt_z      = cnt == '0;
    assign skip_erase = mode == 2'b10;
    assign skip_write = mode == 2'b01;

    // clr counts cycles spent in CLEAR; it wraps to re-issue the clear pulse while busy stays stuck
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt_z ? '0 : cnt - 1'b1;
        clr_nx   = clr;
        mode_nx  = mode;
        err_nx   = prog_err;
        case (state)
            IDLE: if (wbusy_s) begin
                state_nx = PUMP;
                cnt_nx   = LD_PUMP;
                mode_nx  = prog_mode;
                err_nx   = 1'b0;
            end
            PUMP: if (cnt_z) begin
                state_nx = skip_erase ? WRITE : ERASE;
                cnt_nx   = skip_erase ? LD_WRITE : LD_ERASE;
            end
            ERASE: if (cnt_z) begin
                state_nx = skip_write ? DISCH : WRITE;
                cnt_nx   = skip_write ? LD_DISCH : LD_WRITE;
            end
            WRITE: if (cnt_z) begin
                state_nx = DISCH;
                cnt_nx   = LD_DISCH;
            end
            DISCH: if (cnt_z) begin
                state_nx = CLEAR;
                clr_nx   = '0;
            end
            CLEAR: begin
                clr_nx   = (clr == CLR_TOP) ? (wbusy_s ? '0 : clr) : clr + 1'b1;
                state_nx = (!wbusy_s && clr >= CLR_LAST) ? IDLE : CLEAR;
            end
            default: state_nx = IDLE;
        endcase
        if (abort) begin
            state_nx = DISCH;
            cnt_nx   = LD_DISCH;
            err_nx   = 1'b1;
        end
    end

    // outputs decode the next state so they change on the same edge as the state
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync            <= '0;
            state           <= IDLE;
            cnt             <= '0;
            clr             <= '0;
            mode            <= '0;
            hv_pump_en      <= 1'b0;
            ee_erase        <= 1'b0;
            ee_write        <= 1'b0;
            hv_disch        <= 1'b0;
            spi_wbusy_rst_n <= 1'b0;
            prog_busy       <= 1'b0;
            prog_done       <= 1'b0;
            prog_err        <= 1'b0;
        end else begin
            sync            <= {sync[0], spi_ee_wbusy};
            state           <= state_nx;
            cnt             <= cnt_nx;
            clr             <= clr_nx;
            mode            <= mode_nx;
            hv_pump_en      <= state_nx == PUMP || state_nx == ERASE || state_nx == WRITE;
            ee_erase        <= state_nx == ERASE;
            ee_write        <= state_nx == WRITE;
            hv_disch        <= state_nx == DISCH;
            spi_wbusy_rst_n <= !(state_nx == CLEAR && clr_nx < CLR_LOW);
            prog_busy       <= state_nx != IDLE;
            prog_done       <= state_nx == CLEAR && state != CLEAR;
            prog_err        <= err_nx;
        end
    end
endmodule
